// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell: sum and carry of three input bits.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one
// full_adder cell, with the carry held in a flop between bits.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= S_RUN;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    carry_q <= fa_carry;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    r_sh    <= {fa_sum, r_sh[WIDTH-1:1]};
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_out <= {fa_sum, r_sh[WIDTH-1:1]};
                        cout    <= fa_carry;
                        state   <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with WIDTH = 8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;

    int checks = 0;
    int passed = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    // Present operands with start for exactly one edge; returns #1 after that edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Number of edges until done is seen (sampled #1 after each edge), or -1.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a_in  = 8'h11;
        b_in  = 8'h22;
        cin   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done, sum_out, cout} !== {1'b0, 1'b0, 8'h00, 1'b0})
                $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b expected 0/0/00/0",
                         busy, done, sum_out, cout);
            else passed++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_no_start: got busy=%b expected 0", busy);
        else passed++;
    endtask

    task automatic test_basic();
        int n;
        start_op(8'h05, 8'h03, 1'b0);
        checks++;
        if ({busy, done} !== 2'b10) $display("FAIL basic_busy_at_k: got busy=%b done=%b expected 1/0", busy, done);
        else passed++;
        wait_done(n);
        checks++;
        if (n !== 8) $display("FAIL basic_latency: got %0d edges expected 8", n);
        else passed++;
        checks++;
        if ({sum_out, cout} !== {8'h08, 1'b0}) $display("FAIL basic_sum: got %h/%b expected 08/0", sum_out, cout);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL basic_done_pulse: got busy=%b done=%b expected 0/0", busy, done);
        else passed++;
        checks++;
        if (sum_out !== 8'h08) $display("FAIL basic_hold: got %h expected 08", sum_out);
        else passed++;
    endtask

    task automatic test_wrap();
        int n;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(n);
        checks++;
        if (n !== 8 || {sum_out, cout} !== {8'h00, 1'b1})
            $display("FAIL wrap_ff_01: got n=%0d sum=%h cout=%b expected 8/00/1", n, sum_out, cout);
        else passed++;
        @(posedge clk); #1;
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(n);
        checks++;
        if (n !== 8 || {sum_out, cout} !== {8'hFF, 1'b1})
            $display("FAIL wrap_ff_ff_c: got n=%0d sum=%h cout=%b expected 8/FF/1", n, sum_out, cout);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        start_op(8'h10, 8'h20, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if ({sum_out, cout} !== {8'h30, 1'b0})
                    $display("FAIL ignore_sum: got %h/%b expected 30/0", sum_out, cout);
                else passed++;
            end
        end
        checks++;
        if (dones !== 1) $display("FAIL ignore_one_done: got %0d pulses expected 1", dones);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL ignore_idle: got busy=%b expected 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        a_in  = 8'h7F;
        b_in  = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        // n counts edges from the first accepting edge (n = 0).
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== ((n % 10) == 8) || busy !== ((n % 10) != 9))
                $display("FAIL b2b_timing n=%0d: got busy=%b done=%b expected %b/%b",
                         n, busy, done, (n % 10) != 9, (n % 10) == 8);
            else passed++;
            if ((n % 10) == 8) begin
                checks++;
                if ({sum_out, cout} !== {8'h80, 1'b0})
                    $display("FAIL b2b_sum n=%0d: got %h/%b expected 80/0", n, sum_out, cout);
                else passed++;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int n;
        start_op(8'hC3, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({busy, done, sum_out, cout} !== {1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b expected 0/0/00/0",
                     busy, done, sum_out, cout);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) $display("FAIL midreset_abandoned: got %0d active cycles expected 0", dones);
        else passed++;
        start_op(8'h12, 8'h34, 1'b1);
        wait_done(n);
        checks++;
        if (n !== 8 || {sum_out, cout} !== {8'h47, 1'b0})
            $display("FAIL midreset_next_op: got n=%0d sum=%h cout=%b expected 8/47/0", n, sum_out, cout);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
